// File: rtl/stack_ram_if.sv
// Request/response bus between a master and stack_ram.
//
// Handshake: the master raises valid for one cycle per request with addr,
// size, write and wdata stable in that cycle. There is no backpressure; the
// slave answers every request with a one-cycle ready pulse in the following
// cycle, with err and rdata valid while ready is high. valid may stay high
// while ready is high, giving back-to-back requests with no bubble.
interface stack_ram_if;
    logic [31:0] addr;
    logic [2:0]  size;
    logic        valid;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output addr, size, valid, write, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  addr, size, valid, write, wdata,
        output rdata, ready, err
    );
endinterface

// File: rtl/stack_ram.sv
// Single-cycle-latency byte-lane-writable 32-bit word RAM with error
// detection, a preload port and load/store completion counters.
// Loads and stores are read at the request edge; a store's lanes are written
// at the edge that ends its ready cycle, so a load issued right behind a store
// to the same word still sees the old contents.
module stack_ram #(
    parameter int          AW   = 10,
    parameter logic [31:0] BASE = 32'h0
) (
    input  logic          clk,
    input  logic          rstb,
    stack_ram_if.slave    bus,
    input  logic          ld_en,
    input  logic [AW-3:0] ld_addr,
    input  logic [31:0]   ld_data,
    output logic [15:0]   rd_cnt,
    output logic [15:0]   wr_cnt,
    output logic          resp_state
);

    localparam int WORDS = 2 ** (AW - 2);

    typedef enum logic {IDLE, RESP} state_t;

    logic [31:0] mem [0:WORDS-1];

    state_t        state;
    logic          ready_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic          p_store;
    logic [AW-3:0] p_idx;
    logic [1:0]    p_lane;
    logic [2:0]    p_size;
    logic [31:0]   p_wdata;

    // Request decode: offset from BASE, range and alignment checks.
    // BASE is expected to be word aligned, so offset low bits equal addr low bits.
    logic [32:0]   off;
    logic          req_oob;
    logic          req_misalign;
    logic          req_err;
    logic [AW-3:0] req_idx;

    assign off     = {1'b0, bus.addr} - {1'b0, BASE};
    assign req_oob = off[32] | (|off[31:AW]);
    assign req_idx = off[AW-1:2];

    // Alignment and size legality for the incoming request.
    always_comb begin
        req_misalign = 1'b0;
        case (bus.size)
            3'd0:    req_misalign = 1'b0;
            3'd1:    req_misalign = off[0];
            3'd2:    req_misalign = |off[1:0];
            default: req_misalign = 1'b1;
        endcase
    end

    assign req_err = req_oob | req_misalign;

    // Response stage: one-deep pipeline holding the accepted request.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            rd_cnt  <= 16'h0;
            wr_cnt  <= 16'h0;
            p_store <= 1'b0;
            p_idx   <= '0;
            p_lane  <= 2'b00;
            p_size  <= 3'd0;
            p_wdata <= 32'h0;
        end else if (bus.valid) begin
            state   <= RESP;
            ready_q <= 1'b1;
            err_q   <= req_err;
            rdata_q <= req_err ? 32'h0 : mem[req_idx];
            p_store <= bus.write & ~req_err;
            p_idx   <= req_idx;
            p_lane  <= off[1:0];
            p_size  <= bus.size;
            p_wdata <= bus.wdata;
            if (!req_err) begin
                if (bus.write) begin
                    if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
                end else begin
                    if (rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
                end
            end
        end else begin
            state   <= IDLE;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            p_store <= 1'b0;
        end
    end

    // Lane enables and lane-replicated store data for the pending store.
    logic [3:0]  wmask;
    logic [31:0] wlanes;

    always_comb begin
        wmask  = 4'b0000;
        wlanes = p_wdata;
        case (p_size)
            3'd0: begin
                wmask  = 4'b0001 << p_lane;
                wlanes = {4{p_wdata[7:0]}};
            end
            3'd1: begin
                wmask  = p_lane[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{p_wdata[15:0]}};
            end
            3'd2:    wmask = 4'b1111;
            default: wmask = 4'b0000;
        endcase
    end

    // Memory writes: preload first, bus store lanes overlay it (later NBA wins).
    always_ff @(posedge clk) begin
        if (rstb && ld_en) mem[ld_addr] <= ld_data;
        if (p_store) begin
            for (int k = 0; k < 4; k++) begin
                if (wmask[k]) mem[p_idx][8*k +: 8] <= wlanes[8*k +: 8];
            end
        end
    end

    assign bus.ready  = ready_q;
    assign bus.err    = err_q;
    assign bus.rdata  = rdata_q;
    assign resp_state = (state == RESP);

endmodule

// File: tb/tb_stack_ram.sv
// Bench for stack_ram: directed scenarios followed by random traffic, all
// checked against a byte-array model of the memory.
module tb_stack_ram;
    localparam int          AW   = 10;
    localparam logic [31:0] BASE = 32'h0;
    localparam int          NBYTES = 2 ** AW;

    logic        clk;
    logic        rstb;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
    logic        resp_state;

    stack_ram_if bus_if ();

    stack_ram #(.AW(AW), .BASE(BASE)) dut (
        .clk        (clk),
        .rstb       (rstb),
        .bus        (bus_if.slave),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .rd_cnt     (rd_cnt),
        .wr_cnt     (wr_cnt),
        .resp_state (resp_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [7:0]  mb [0:NBYTES-1];
    logic        exp_ready, exp_err;
    logic [31:0] exp_rdata;
    int          rd_exp, wr_exp;
    bit          pend_v;
    logic [31:0] pend_off, pend_data;
    logic [2:0]  pend_size;
    int          n_checks, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] off);
        int w;
        w = int'(off) & ~3;
        return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endfunction

    // Error when outside the window, size unknown, or not naturally aligned.
    function automatic bit is_err(input logic [31:0] a, input logic [2:0] s);
        longint la, lb;
        int n;
        la = longint'(a);
        lb = longint'(BASE);
        if (s > 3'd2) return 1'b1;
        if (la < lb || la >= lb + NBYTES) return 1'b1;
        n = 1 << s;
        return ((la - lb) % n) != 0;
    endfunction

    function automatic int sat_inc(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    task automatic check_outputs();
        chk("ready", {31'b0, bus_if.ready}, {31'b0, exp_ready});
        chk("err", {31'b0, bus_if.err}, {31'b0, exp_err});
        chk("rdata", bus_if.rdata, exp_rdata);
        chk("rd_cnt", {16'b0, rd_cnt}, rd_exp[31:0]);
        chk("wr_cnt", {16'b0, wr_cnt}, wr_exp[31:0]);
        chk("resp_state", {31'b0, resp_state}, {31'b0, exp_ready});
    endtask

    // One cycle: check the response to the previous request, update the model
    // for the writes landing on the next edge, and drive this cycle's inputs.
    task automatic step(input bit v, input bit w, input logic [31:0] a,
                        input logic [2:0] s, input logic [31:0] d,
                        input bit ld, input logic [7:0] la, input logic [31:0] ldd);
        bit e;
        @(negedge clk);
        check_outputs();
        e = 1'b0;
        if (v) begin
            e = is_err(a, s);
            exp_ready = 1'b1;
            exp_err   = e;
            exp_rdata = e ? 32'h0 : mword(a - BASE);
            if (!e) begin
                if (w) wr_exp = sat_inc(wr_exp);
                else   rd_exp = sat_inc(rd_exp);
            end
        end else begin
            exp_ready = 1'b0;
            exp_err   = 1'b0;
        end
        if (ld) begin
            for (int i = 0; i < 4; i++) mb[int'(la) * 4 + i] = ldd[8*i +: 8];
        end
        if (pend_v) begin
            for (int i = 0; i < (1 << pend_size); i++)
                mb[int'(pend_off) + i] = pend_data[8*i +: 8];
        end
        pend_v    = v && w && !e;
        pend_off  = a - BASE;
        pend_size = s;
        pend_data = d;
        bus_if.valid = v;
        bus_if.write = w;
        bus_if.addr  = a;
        bus_if.size  = s;
        bus_if.wdata = d;
        ld_en   = ld;
        ld_addr = la;
        ld_data = ldd;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 8'h0, 32'h0);
    endtask

    task automatic req(input bit w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        step(1'b1, w, a, s, d, 1'b0, 8'h0, 32'h0);
    endtask

    logic [31:0] old8;
    logic [31:0] err_addr [4];
    logic [2:0]  err_size [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rd_exp   = 0;
        wr_exp   = 0;
        pend_v   = 1'b0;
        pend_off = 32'h0;
        pend_size = 3'd0;
        pend_data = 32'h0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        rstb = 1'b0;
        bus_if.valid = 1'b0;
        bus_if.write = 1'b0;
        bus_if.addr  = 32'h0;
        bus_if.size  = 3'd0;
        bus_if.wdata = 32'h0;
        ld_en   = 1'b0;
        ld_addr = 8'h0;
        ld_data = 32'h0;

        // Reset state
        #3;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstb = 1'b1;

        // Fill the whole array through the preload port
        for (int i = 0; i < NBYTES / 4; i++)
            step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 8'(i), $urandom);

        // Preload then load word at 0x4
        step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 8'd1, 32'h44332211);
        req(1'b0, 32'h4, 3'd2, 32'h0);
        idle();
        chk("load_0x4_rdata", bus_if.rdata, 32'h44332211);
        chk("load_0x4_rd_cnt", {16'b0, rd_cnt}, 32'd1);

        // Byte then half store over the same word
        req(1'b1, 32'h6, 3'd0, 32'h000000AB);
        req(1'b1, 32'h4, 3'd1, 32'h0000BEEF);
        idle();
        req(1'b0, 32'h4, 3'd2, 32'h0);
        idle();
        chk("store_merge_rdata", bus_if.rdata, 32'h44ABBEEF);
        chk("store_merge_wr_cnt", {16'b0, wr_cnt}, 32'd2);

        // Back-to-back store/load/load to 0x8
        old8 = mword(32'h8);
        req(1'b1, 32'h8, 3'd2, 32'hDEADBEEF);
        req(1'b0, 32'h8, 3'd2, 32'h0);
        chk("b2b_ready1", {31'b0, bus_if.ready}, 32'd1);
        req(1'b0, 32'h8, 3'd2, 32'h0);
        chk("b2b_ready2", {31'b0, bus_if.ready}, 32'd1);
        chk("b2b_load_old", bus_if.rdata, old8);
        idle();
        chk("b2b_ready3", {31'b0, bus_if.ready}, 32'd1);
        chk("b2b_load_new", bus_if.rdata, 32'hDEADBEEF);

        // Error responses: misaligned word, misaligned half, bad size, out of range
        err_addr[0] = 32'h2;  err_size[0] = 3'd2;
        err_addr[1] = 32'h5;  err_size[1] = 3'd1;
        err_addr[2] = 32'h8;  err_size[2] = 3'd3;
        err_addr[3] = BASE + 32'(NBYTES); err_size[3] = 3'd2;
        for (int i = 0; i < 4; i++) begin
            req(1'b1, err_addr[i], err_size[i], 32'hFFFFFFFF);
            idle();
            chk("err_flag", {31'b0, bus_if.err}, 32'd1);
            chk("err_rdata", bus_if.rdata, 32'h0);
        end
        req(1'b0, 32'h0, 3'd2, 32'h0);
        req(1'b0, 32'h4, 3'd2, 32'h0);
        req(1'b0, 32'h8, 3'd2, 32'h0);
        idle();
        chk("err_mem_kept", bus_if.rdata, 32'hDEADBEEF);

        // Preload and byte store on word 0xC in the same edge: store lane wins
        req(1'b1, 32'hF, 3'd0, 32'h0000005A);
        step(1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 8'd3, 32'h0);
        req(1'b0, 32'hC, 3'd2, 32'h0);
        idle();
        chk("overlay_rdata", bus_if.rdata, 32'h5A000000);

        // Reset during a store's response cycle
        req(1'b1, 32'h10, 3'd2, 32'h12345678);
        @(posedge clk);
        #2;
        rstb = 1'b0;
        bus_if.valid = 1'b1;
        bus_if.write = 1'b1;
        bus_if.addr  = 32'h14;
        bus_if.size  = 3'd2;
        bus_if.wdata = 32'h0BADF00D;
        ld_en   = 1'b1;
        ld_addr = 8'd5;
        ld_data = 32'hCAFEF00D;
        pend_v = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'h0;
        rd_exp = 0;
        wr_exp = 0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        bus_if.valid = 1'b0;
        bus_if.write = 1'b0;
        ld_en = 1'b0;
        rstb = 1'b1;
        idle();
        idle();
        req(1'b0, 32'h10, 3'd2, 32'h0);
        req(1'b0, 32'h14, 3'd2, 32'h0);
        req(1'b0, 32'h4, 3'd2, 32'h0);
        idle();
        chk("post_reset_preload", bus_if.rdata, 32'h44ABBEEF);

        // Random traffic with interleaved preloads
        for (int n = 0; n < 400; n++) begin
            bit          v, w, ld;
            logic [31:0] a;
            logic [2:0]  s;
            int          r;
            v = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 7));
            else             a = BASE + 32'($urandom_range(0, NBYTES - 1));
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            ld = ($urandom_range(0, 7) == 0);
            step(v, w, a, s, $urandom, ld, 8'($urandom_range(0, 255)), $urandom);
        end
        idle();
        // Read back every word to sweep the model against the array
        for (int i = 0; i < NBYTES / 4; i++) req(1'b0, BASE + 32'(i * 4), 3'd2, 32'h0);
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
